// File: rtl/marker_chk_if.sv
// marker_chk_if: rate config, received marker beats and checker status bundled between driver and marker_chk.
interface marker_chk_if;
    logic [3:0]  local_rate;
    logic [3:0]  remote_rate;
    logic        rx_valid;
    logic [3:0]  rx_marker;
    logic        clr_err;
    logic        locked;
    logic [1:0]  phase;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        first_err_valid;
    logic [3:0]  first_err_data;
    logic [3:0]  first_err_exp;
    modport master (
        output local_rate, remote_rate, rx_valid, rx_marker, clr_err,
        input  locked, phase, err_pulse, err_count, first_err_valid, first_err_data, first_err_exp
    );
    modport slave (
        input  local_rate, remote_rate, rx_valid, rx_marker, clr_err,
        output locked, phase, err_pulse, err_count, first_err_valid, first_err_data, first_err_exp
    );
endinterface

// File: rtl/marker_chk.sv
// marker_chk: hunts for marker phase alignment, locks, then flags and counts mismatches.
// MARKER_CHK_FIRST_ERR_EN builds the first-error capture registers.
module marker_chk #(
    parameter int LOCK_CNT   = 4,
    parameter int MISS_LIMIT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    marker_chk_if.slave  bus
);
    typedef enum logic {HUNT, LOCKED} state_t;
    state_t      state;
    logic [3:0]  local_q, remote_q, match_cnt, miss_cnt, exp, mask;
    logic        legal, hit, chg, err_ev;
    always_comb begin
        legal  = (bus.local_rate == 4'h1 || bus.local_rate == 4'h2 || bus.local_rate == 4'h4) &&
                 (bus.remote_rate == 4'h1 || bus.remote_rate == 4'h2 || bus.remote_rate == 4'h4);
        mask   = bus.local_rate == 4'h1 ? 4'b0001 : bus.local_rate == 4'h2 ? 4'b0011 : 4'b1111;
        case ({bus.local_rate, bus.remote_rate})
            8'h11:   exp = 4'b0001;
            8'h12:   exp = bus.phase[0] ? 4'b0001 : 4'b0000;
            8'h14:   exp = bus.phase == 2'd3 ? 4'b0001 : 4'b0000;
            8'h21:   exp = 4'b0011;
            8'h22:   exp = 4'b0010;
            8'h24:   exp = bus.phase[0] ? 4'b0010 : 4'b0000;
            8'h41:   exp = 4'b1111;
            8'h42:   exp = 4'b1010;
            8'h44:   exp = 4'b1000;
            default: exp = 4'b0000;
        endcase
        hit    = ((bus.rx_marker ^ exp) & mask) == 4'b0000;
        chg    = bus.local_rate != local_q || bus.remote_rate != remote_q;
        err_ev = !chg && legal && bus.rx_valid && state == LOCKED && !hit;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= HUNT;
            local_q       <= 4'h0;
            remote_q      <= 4'h0;
            match_cnt     <= 4'd0;
            miss_cnt      <= 4'd0;
            bus.locked    <= 1'b0;
            bus.phase     <= 2'd0;
            bus.err_pulse <= 1'b0;
            bus.err_count <= 16'd0;
        end else begin
            local_q       <= bus.local_rate;
            remote_q      <= bus.remote_rate;
            bus.err_pulse <= err_ev;
            if (chg) begin
                state      <= HUNT;
                bus.locked <= 1'b0;
                match_cnt  <= 4'd0;
                miss_cnt   <= 4'd0;
                bus.phase  <= 2'd0;
            end else if (!legal) begin
                state      <= HUNT;
                bus.locked <= 1'b0;
                match_cnt  <= 4'd0;
            end else if (bus.rx_valid && state == HUNT) begin
                // a mismatch slips one extra beat to try the next alignment
                bus.phase <= bus.phase + (hit ? 2'd1 : 2'd2);
                match_cnt <= hit ? match_cnt + 4'd1 : 4'd0;
                if (hit && match_cnt + 4'd1 == 4'(LOCK_CNT)) begin
                    state      <= LOCKED;
                    bus.locked <= 1'b1;
                    miss_cnt   <= 4'd0;
                end
            end else if (bus.rx_valid) begin
                bus.phase <= bus.phase + 2'd1;
                miss_cnt  <= hit ? 4'd0 : miss_cnt + 4'd1;
                if (!hit) begin
                    bus.err_count <= &bus.err_count ? bus.err_count : bus.err_count + 16'd1;
                    if (miss_cnt + 4'd1 == 4'(MISS_LIMIT)) begin
                        state      <= HUNT;
                        bus.locked <= 1'b0;
                        match_cnt  <= 4'd0;
                    end
                end
            end
            if (bus.clr_err) bus.err_count <= 16'd0;
        end
    end
`ifdef MARKER_CHK_FIRST_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.first_err_valid <= 1'b0;
            bus.first_err_data  <= 4'd0;
            bus.first_err_exp   <= 4'd0;
        end else if (bus.clr_err) begin
            bus.first_err_valid <= 1'b0;
        end else if (err_ev && !bus.first_err_valid) begin
            bus.first_err_valid <= 1'b1;
            bus.first_err_data  <= bus.rx_marker & mask;
            bus.first_err_exp   <= exp & mask;
        end
    end
`else
    assign bus.first_err_valid = 1'b0;
    assign bus.first_err_data  = 4'd0;
    assign bus.first_err_exp   = 4'd0;
`endif
endmodule

// File: tb/tb_marker_chk.sv
// tb_marker_chk: directed scenario tasks with hand-computed expectations for marker_chk.
module tb_marker_chk;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    marker_chk_if bus();
    marker_chk dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic beat(input logic [3:0] m, input logic clr = 1'b0);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_marker = m;
        bus.clr_err = clr;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    task automatic idle(input int n, input logic clr = 1'b0);
        repeat (n) begin
            @(negedge clk);
            bus.clr_err = clr;
            @(posedge clk);
            #1;
            bus.clr_err = 1'b0;
        end
    endtask

    task automatic set_rate(input logic [3:0] l, input logic [3:0] r);
        @(negedge clk);
        bus.local_rate = l;
        bus.remote_rate = r;
        @(posedge clk);
        #1;
        idle(1);
    endtask

    task automatic test_reset;
        bus.local_rate = 4'h1; bus.remote_rate = 4'h1;
        bus.rx_valid = 1'b0; bus.rx_marker = 4'h0; bus.clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", bus.locked); end
        total++; if (bus.phase !== 2'd0) begin bad++; $display("FAIL reset_phase got=%0d exp=0", bus.phase); end
        total++; if (bus.err_count !== 16'd0 || bus.err_pulse !== 1'b0) begin bad++; $display("FAIL reset_err got=%h/%b exp=0/0", bus.err_count, bus.err_pulse); end
        total++; if ({bus.first_err_valid, bus.first_err_data, bus.first_err_exp} !== 9'd0) begin bad++; $display("FAIL reset_first got=%b exp=0", {bus.first_err_valid, bus.first_err_data, bus.first_err_exp}); end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_align;
        int lock_at = -1;
        set_rate(4'h1, 4'h4);
        for (int i = 0; i < 12; i++) begin
            beat(((i + 2) % 4 == 3) ? 4'h1 : 4'h0);
            if (bus.locked === 1'b1 && lock_at < 0) lock_at = i;
        end
        total++; if (lock_at !== 6) begin bad++; $display("FAIL align_lock_beat got=%0d exp=6", lock_at); end
        beat(4'h0);
        total++; if (bus.phase !== 2'd3) begin bad++; $display("FAIL align_phase got=%0d exp=3", bus.phase); end
        beat(4'h1);
        total++; if (bus.err_count !== 16'd0 || bus.locked !== 1'b1) begin bad++; $display("FAIL align_clean got=%h/%b exp=0000/1", bus.err_count, bus.locked); end
    endtask

    task automatic test_single_err;
        set_rate(4'h4, 4'h4);
        repeat (4) beat(4'b1000);
        total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL qq_lock got=%b exp=1", bus.locked); end
        beat(4'b0000);
        total++; if (bus.err_pulse !== 1'b1 || bus.err_count !== 16'd1 || bus.locked !== 1'b1) begin bad++; $display("FAIL qq_err got=%b/%h/%b exp=1/0001/1", bus.err_pulse, bus.err_count, bus.locked); end
        beat(4'b1000);
        total++; if (bus.err_pulse !== 1'b0) begin bad++; $display("FAIL qq_pulse_once got=%b exp=0", bus.err_pulse); end
        idle(3);
        total++; if (bus.phase !== 2'd2) begin bad++; $display("FAIL qq_gap_phase got=%0d exp=2", bus.phase); end
`ifdef MARKER_CHK_FIRST_ERR_EN
        total++; if ({bus.first_err_valid, bus.first_err_data, bus.first_err_exp} !== {1'b1, 4'b0000, 4'b1000}) begin bad++; $display("FAIL qq_first got=%b exp=100001000", {bus.first_err_valid, bus.first_err_data, bus.first_err_exp}); end
`else
        total++; if ({bus.first_err_valid, bus.first_err_data, bus.first_err_exp} !== 9'd0) begin bad++; $display("FAIL qq_first got=%b exp=0", {bus.first_err_valid, bus.first_err_data, bus.first_err_exp}); end
`endif
    endtask

    task automatic test_miss_relock;
        set_rate(4'h2, 4'h2);
        idle(1, 1'b1);
        total++; if (bus.err_count !== 16'd0) begin bad++; $display("FAIL hh_clr got=%h exp=0000", bus.err_count); end
        repeat (4) beat(4'b0010);
        repeat (2) beat(4'b0001);
        total++; if (bus.locked !== 1'b1 || bus.err_count !== 16'd2) begin bad++; $display("FAIL hh_miss2 got=%b/%h exp=1/0002", bus.locked, bus.err_count); end
        beat(4'b0001);
        total++; if (bus.locked !== 1'b0 || bus.err_count !== 16'd3 || bus.err_pulse !== 1'b1) begin bad++; $display("FAIL hh_drop got=%b/%h/%b exp=0/0003/1", bus.locked, bus.err_count, bus.err_pulse); end
        repeat (3) beat(4'b0010);
        total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL hh_relock3 got=%b exp=0", bus.locked); end
        beat(4'b0010);
        total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL hh_relock4 got=%b exp=1", bus.locked); end
    endtask

    task automatic test_rate_change;
        set_rate(4'h1, 4'h1);
        repeat (4) beat(4'h1);
        total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL ff_lock got=%b exp=1", bus.locked); end
        @(negedge clk);
        bus.local_rate = 4'h2;
        bus.rx_valid = 1'b1;
        bus.rx_marker = 4'h1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        total++; if (bus.locked !== 1'b0 || bus.err_count !== 16'd3 || bus.phase !== 2'd0) begin bad++; $display("FAIL chg_drop got=%b/%h/%0d exp=0/0003/0", bus.locked, bus.err_count, bus.phase); end
        repeat (3) beat(4'b0011);
        total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL hf_lock3 got=%b exp=0", bus.locked); end
        beat(4'b0011);
        total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL hf_lock4 got=%b exp=1", bus.locked); end
    endtask

    task automatic test_illegal;
        for (int s = 0; s < 2; s++) begin
            logic seen = 1'b0;
            if (s == 0) set_rate(4'h3, 4'h1); else set_rate(4'h1, 4'h0);
            idle(1, 1'b1);
            repeat (100) begin
                beat(4'($urandom));
                if (bus.locked !== 1'b0) seen = 1'b1;
            end
            total++; if (seen !== 1'b0 || bus.err_count !== 16'd0) begin bad++; $display("FAIL illegal_%0d got=%b/%h exp=0/0000", s, seen, bus.err_count); end
        end
    endtask

    task automatic test_saturate;
        set_rate(4'h1, 4'h1);
        repeat (4) beat(4'h1);
        @(negedge clk);
        force bus.err_count = 16'hFFFF;
        #1;
        release bus.err_count;
        beat(4'h0);
        total++; if (bus.err_count !== 16'hFFFF || bus.err_pulse !== 1'b1) begin bad++; $display("FAIL sat got=%h/%b exp=ffff/1", bus.err_count, bus.err_pulse); end
        beat(4'h0, 1'b1);
        total++; if (bus.err_count !== 16'd0 || bus.err_pulse !== 1'b1) begin bad++; $display("FAIL clr_vs_err got=%h/%b exp=0000/1", bus.err_count, bus.err_pulse); end
    endtask

    task automatic test_async_reset;
        beat(4'h1);
        beat(4'h0);
        total++; if (bus.err_count !== 16'd1 || bus.locked !== 1'b1) begin bad++; $display("FAIL pre_rst got=%h/%b exp=0001/1", bus.err_count, bus.locked); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.locked !== 1'b0 || bus.err_count !== 16'd0 || bus.phase !== 2'd0) begin bad++; $display("FAIL async_rst got=%b/%h/%0d exp=0/0000/0", bus.locked, bus.err_count, bus.phase); end
        idle(1);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset;
        test_align;
        test_single_err;
        test_miss_relock;
        test_rate_change;
        test_illegal;
        test_saturate;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
